// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, oversampling and
// character-size limits, plus small helpers used by the receiver datapath.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned CHAR_MIN   = 5;
    localparam int unsigned CHAR_MAX   = 8;
    localparam int unsigned SIZE_W     = 4;

    // Clamp the requested character size into the supported range.
    function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] cs);
        if (cs < SIZE_W'(CHAR_MIN)) begin
            return SIZE_W'(CHAR_MIN);
        end else if (cs > SIZE_W'(CHAR_MAX)) begin
            return SIZE_W'(CHAR_MAX);
        end
        return cs;
    endfunction

    // Keep only the low eff bits of a received character.
    function automatic logic [CHAR_MAX-1:0] char_mask(input logic [SIZE_W-1:0] eff);
        logic [CHAR_MAX-1:0] ones;
        ones = '1;
        return ones >> (SIZE_W'(CHAR_MAX) - eff);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detect on the synchronized value.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic baud16,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic fall_c
);

    logic meta;
    logic rxs_prev;

    always_ff @(posedge baud16) begin
        if (rst) begin
            meta     <= LINE_IDLE;
            rxs      <= LINE_IDLE;
            rxs_prev <= LINE_IDLE;
        end else begin
            meta     <= rx;
            rxs      <= meta;
            rxs_prev <= rxs;
        end
    end

    // A held-low line never re-triggers: the previous sample must be idle.
    assign fall_c = (rxs_prev == LINE_IDLE) && (rxs == LINE_START);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled start/data/stop framing with 5-8 data bits,
// framing-error and overrun reporting, and a read strobe that clears status.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       baud16,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] char_size,
    input  logic       re,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    import uart_pkg::*;

    localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W  = $clog2(CHAR_MAX);
    localparam int unsigned DATA_W = CHAR_MAX;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic rxs;
    logic fall_c;

    uart_state_e        state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [DATA_W-1:0]  shift_q,  shift_d;
    logic [DATA_W-1:0]  data_d;
    logic               done_d;
    logic               ferr_d;
    logic               ovr_d;
    logic               busy_d;
    logic [SIZE_W-1:0]  eff;
    logic               complete;

    uart_rx_sync u_sync (
        .baud16 (baud16),
        .rst    (rst),
        .rx     (rx),
        .rxs    (rxs),
        .fall_c (fall_c)
    );

    // State, datapath and status registers.
    always_ff @(posedge baud16) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_out  <= data_d;
            rx_done   <= done_d;
            frame_err <= ferr_d;
            overrun   <= ovr_d;
            rx_busy   <= busy_d;
        end
    end

    // Next-state, sampling and status update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_out;
        done_d   = rx_done;
        ferr_d   = frame_err;
        ovr_d    = overrun;
        complete = 1'b0;
        eff      = eff_size(char_size);

        case (state_q)
            IDLE: begin
                if (re && fall_c) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (!re) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (rxs == LINE_START) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (!re) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(eff - SIZE_W'(1))) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (!re) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A read on the completion edge frees the buffer for the new character.
        if (complete) begin
            if (!rx_done || rd) begin
                data_d = shift_q & char_mask(eff);
                ferr_d = ~rxs;
                done_d = 1'b1;
                if (rd) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: framing, size clamping, false start,
// framing error/break, overrun, read-on-completion and aborts.
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       baud16;
    logic       rst;
    logic       rx;
    logic [3:0] char_size;
    logic       re;
    logic       rd;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_cmp;
    int n_err;

    int cyc;
    int busy_rise;
    int done_rise;
    int busy_cnt;
    logic busy_q;
    logic done_q;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .baud16    (baud16),
        .rst       (rst),
        .rx        (rx),
        .char_size (char_size),
        .re        (re),
        .rd        (rd),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    initial baud16 = 1'b0;
    always #5 baud16 = ~baud16;

    // Timestamps of rx_busy / rx_done rising edges and a running busy count.
    initial begin
        cyc = 0; busy_rise = 0; done_rise = 0; busy_cnt = 0;
        busy_q = 1'b0; done_q = 1'b0;
    end
    always @(negedge baud16) begin
        cyc = cyc + 1;
        if (rx_busy && !busy_q) busy_rise = cyc;
        if (rx_done && !done_q) done_rise = cyc;
        if (rx_busy) busy_cnt = busy_cnt + 1;
        busy_q = rx_busy;
        done_q = rx_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge baud16);
        #1;
    endtask

    // Drive one frame tick by tick; rd pulses on tick rd_at, drive stops after limit ticks.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic stop_bit,
                              input int rd_at, input int limit);
        int b;
        for (int t = 0; t < 16 * (nbits + 2); t++) begin
            if (t >= limit) break;
            b = t / 16;
            if (b == 0)          rx = 1'b0;
            else if (b <= nbits) rx = d[b-1];
            else                 rx = stop_bit;
            rd = (t == rd_at);
            tick(1);
        end
        rd = 1'b0;
        if (stop_bit && limit >= 16 * (nbits + 2)) rx = 1'b1;
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(1);
    endtask

    int busy_before;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; rx = 1'b1; char_size = 4'd8; re = 1'b1; rd = 1'b0;
        tick(4);
        check("rst_data",  32'(data_out),  32'h00);
        check("rst_done",  32'(rx_done),   32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovr",   32'(overrun),   32'h0);
        check("rst_busy",  32'(rx_busy),   32'h0);
        rst = 1'b0;
        tick(4);

        // 8-bit 0xA5 with good stop bit, latency 152 ticks
        send_frame(8'hA5, 8, 1'b1, -1, 1000);
        check("a5_data",    32'(data_out),  32'hA5);
        check("a5_done",    32'(rx_done),   32'h1);
        check("a5_ferr",    32'(frame_err), 32'h0);
        check("a5_busy",    32'(rx_busy),   32'h0);
        check("a5_latency", 32'(done_rise - busy_rise), 32'd152);
        read_pulse();
        check("a5_rd_done", 32'(rx_done),   32'h0);
        tick(4);

        // char_size=12 behaves as 8
        char_size = 4'd12;
        send_frame(8'hC3, 8, 1'b1, -1, 1000);
        check("cs12_data", 32'(data_out), 32'hC3);
        read_pulse();
        tick(4);

        // char_size=5; upper shift bits from 0xC3 must be masked off
        char_size = 4'd5;
        send_frame(8'h1F, 5, 1'b1, -1, 1000);
        check("cs5_data",    32'(data_out), 32'h1F);
        check("cs5_latency", 32'(done_rise - busy_rise), 32'd104);
        read_pulse();
        tick(4);

        // char_size=3 behaves as 5
        char_size = 4'd3;
        send_frame(8'h16, 5, 1'b1, -1, 1000);
        check("cs3_data", 32'(data_out), 32'h16);
        check("cs3_done", 32'(rx_done),  32'h1);
        read_pulse();
        char_size = 4'd8;
        tick(4);

        // False start: line low for 4 ticks only
        busy_before = busy_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        check("fs_done",      32'(rx_done), 32'h0);
        check("fs_busy",      32'(rx_busy), 32'h0);
        check("fs_pulse_max", 32'((busy_cnt - busy_before) <= 8), 32'h1);
        check("fs_pulse_min", 32'((busy_cnt - busy_before) > 0),  32'h1);
        check("fs_data",      32'(data_out), 32'h16);

        // Framing error then break: only one character
        send_frame(8'h3C, 8, 1'b0, -1, 1000);
        check("fe_data", 32'(data_out),  32'h3C);
        check("fe_ferr", 32'(frame_err), 32'h1);
        check("fe_done", 32'(rx_done),   32'h1);
        read_pulse();
        tick(200);
        check("brk_done", 32'(rx_done), 32'h0);
        check("brk_busy", 32'(rx_busy), 32'h0);
        rx = 1'b1;
        tick(20);

        // Overrun: two frames without read
        send_frame(8'h11, 8, 1'b1, -1, 1000);
        tick(2);
        check("ov1_ferr", 32'(frame_err), 32'h0);
        send_frame(8'h22, 8, 1'b1, -1, 1000);
        tick(2);
        check("ov_data", 32'(data_out), 32'h11);
        check("ov_flag", 32'(overrun),  32'h1);
        check("ov_done", 32'(rx_done),  32'h1);
        read_pulse();
        check("ov_rd_done", 32'(rx_done), 32'h0);
        check("ov_rd_ovr",  32'(overrun), 32'h0);
        tick(4);

        // Read on the completion edge accepts the new character
        send_frame(8'h11, 8, 1'b1, -1, 1000);
        tick(2);
        send_frame(8'h7E, 8, 1'b1, -1, 1000);
        tick(2);
        check("rc_pre_ovr", 32'(overrun), 32'h1);
        send_frame(8'h22, 8, 1'b1, 154, 1000);
        tick(2);
        check("rc_data", 32'(data_out), 32'h22);
        check("rc_done", 32'(rx_done),  32'h1);
        check("rc_ovr",  32'(overrun),  32'h0);

        // re=0 during data bit 3: abort, flags held
        send_frame(8'h99, 8, 1'b1, -1, 72);
        check("re_mid_busy", 32'(rx_busy), 32'h1);
        re = 1'b0;
        tick(1);
        check("re_busy", 32'(rx_busy), 32'h0);
        rx = 1'b1;
        tick(40);
        re = 1'b1;
        check("re_data", 32'(data_out), 32'h22);
        check("re_done", 32'(rx_done),  32'h1);
        check("re_ovr",  32'(overrun),  32'h0);
        read_pulse();
        tick(4);
        send_frame(8'h5A, 8, 1'b1, -1, 1000);
        tick(2);
        check("re_next_data", 32'(data_out), 32'h5A);
        check("re_next_done", 32'(rx_done),  32'h1);

        // rst during data bit 3: everything cleared, next frame good
        send_frame(8'h99, 8, 1'b1, -1, 72);
        rst = 1'b1;
        tick(1);
        rx = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rst_mid_busy", 32'(rx_busy),   32'h0);
        check("rst_mid_done", 32'(rx_done),   32'h0);
        check("rst_mid_data", 32'(data_out),  32'h00);
        check("rst_mid_ferr", 32'(frame_err), 32'h0);
        tick(40);
        check("rst_idle_busy", 32'(rx_busy), 32'h0);
        send_frame(8'h5A, 8, 1'b1, -1, 1000);
        tick(2);
        check("rst_next_data", 32'(data_out), 32'h5A);
        check("rst_next_done", 32'(rx_done),  32'h1);
        check("rst_next_ferr", 32'(frame_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port baud16, input, 1: clock, rising edge, 16x the bit rate.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port rx, input, 1: serial line, asynchronous; idle high.
REQ-004 SHALL have port char_size, input, 4: data bits per character, 5-8.
REQ-005 SHALL have port re, input, 1: receiver enable.
REQ-006 SHALL have port rd, input, 1: read strobe; clears rx_done and overrun.
REQ-007 SHALL have port data_out, output, 8: last accepted character, LSB-aligned, unused upper bits 0.
REQ-008 SHALL have port rx_done, output, 1: unread character present in data_out.
REQ-009 SHALL have port frame_err, output, 1: stop-bit status of last accepted character (1 = stop sampled low).
REQ-010 SHALL have port overrun, output, 1: a character completed while rx_done=1 and was discarded.
REQ-011 SHALL have port rx_busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have parameter OVERSAMPLE, default 16: baud16 ticks per bit.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all logic below uses the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE SHALL go to START when re=1 and rxs falls 1->0 (previous rxs=1); tick counter cleared to 0.
REQ-016 START SHALL count ticks; at count 7 (mid start bit), rxs=0 -> DATA with counter and bit index cleared; rxs=1 -> IDLE (false start, no flags touched).
REQ-017 DATA SHALL sample rxs every 16 ticks at mid-bit, LSB first, into shift bit [index], then increment index.
REQ-018 DATA SHALL go to STOP after the sample with index = effective_size-1.
REQ-019 effective_size SHALL be char_size clamped to 5..8 (values <5 use 5, >8 use 8); char_size SHALL be read at each sample.
REQ-020 STOP SHALL sample rxs at mid stop bit, then return to IDLE on the same edge.
REQ-021 On the STOP sample with rx_done=0: data_out <= shift (bits >= effective_size zeroed); frame_err <= ~rxs; rx_done <= 1.
REQ-022 On the STOP sample with rx_done=1 and rd=0: data_out and frame_err SHALL be held; overrun <= 1.
REQ-023 rd=1 with no completion in the same cycle SHALL clear rx_done and overrun next edge.
REQ-024 rd=1 coinciding with a STOP sample SHALL accept the new character per REQ-021; rx_done stays 1 and overrun becomes 0.
REQ-025 re=0 in START/DATA/STOP SHALL abort to IDLE next edge, discarding the partial character; rx_done, overrun, data_out and frame_err are held.
REQ-026 A continuous low line (break) SHALL produce at most one character; a new start requires rxs to return to 1 first.
REQ-027 Latency: rx_done SHALL rise on the edge of the stop-bit mid sample, i.e. 8+16*(effective_size+1) ticks after the start edge is detected on rxs.

Reset
REQ-028 rst SHALL set: state IDLE, counters 0, synchronizer flops 1, data_out 0, rx_done 0, frame_err 0, overrun 0, rx_busy 0.
REQ-029 rst asserted mid-frame SHALL discard the frame; the first edge with rst=0 is in IDLE.

Structure
REQ-030 Shared package uart_pkg SHALL hold: state encoding (2 bits, shared with the transmitter), IDLE=1/START=0 line levels, OVERSAMPLE=16, MID_SAMPLE=7, CHAR_MIN=5, CHAR_MAX=8.
REQ-031 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and the falling-edge detect.

Verification
REQ-032 8-bit 0xA5 with stop=1 -> data_out=0xA5, rx_done=1, frame_err=0, at 152 ticks after the start edge.
REQ-033 char_size=5, byte 0x1F on the line (bits 11111) -> data_out=0x1F; char_size=3 behaves as 5; char_size=12 behaves as 8.
REQ-034 Start low for 4 ticks only -> no rx_done, back to IDLE, rx_busy pulse of at most 8 ticks.
REQ-035 Stop bit driven 0, data 0x3C -> data_out=0x3C, frame_err=1; line held low -> no second character.
REQ-036 Two frames 0x11, 0x22 without rd -> data_out=0x11, overrun=1; rd -> both flags clear; rd on the completion edge of 0x22 -> data_out=0x22, overrun=0.
REQ-037 rst or re=0 during DATA bit 3 -> IDLE, flags unchanged (re case) or cleared (rst case); the next clean frame 0x5A is received correctly.
